// File: rtl/servo_pkg.sv
// servo_pkg: shared types, FSM states and width helpers for the servo frame scheduler
//   width_t      28-bit pulse width in clock ticks
//   ch_idx_t     3-bit channel index
//   state_t      command FSM states
//   slew_step    one frame of slew limiting toward a target
//   pos_to_width position command to pulse width conversion
package servo_pkg;
  typedef logic [27:0] width_t;
  typedef logic [2:0] ch_idx_t;
  typedef enum logic {IDLE, WRITE} state_t;
  // Distances are compared instead of sums so cur+step can never wrap past the target.
  function automatic width_t slew_step(width_t cur, width_t tgt, width_t step);
    return (step == '0) ? tgt :
           (cur < tgt) ? ((tgt - cur > step) ? cur + step : tgt) :
           (cur > tgt) ? ((cur - tgt > step) ? cur - step : tgt) : cur;
  endfunction
  function automatic width_t pos_to_width(logic [7:0] pos, width_t base, width_t scale);
    return base + width_t'(pos) * scale;
  endfunction
endpackage

// File: rtl/servo_slew_channel.sv
// servo_slew_channel: one servo channel, slew-limited once per frame, with PWM compare
//   clk, rst         clock, async active-high reset
//   wr, wr_width     target write strobe and new target width
//   wrap             frame wrap strobe (counter at its last tick)
//   count            shared frame counter
//   enable_q         frame-latched output enable
//   pwm, at_target   pulse output, current width equals target
module servo_slew_channel import servo_pkg::*; #(
  parameter width_t INIT = width_t'(75_088),
  parameter width_t STEP_W = width_t'(500)
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   wr,
  input  width_t wr_width,
  input  logic   wrap,
  input  width_t count,
  input  logic   enable_q,
  output logic   pwm,
  output logic   at_target
);
  width_t target, cur;
  // cur only moves on the wrap edge, so the width is constant across a whole pulse;
  // a write landing on that same edge is seen by the following frame's update.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      target <= INIT;
      cur <= INIT;
    end else begin
      if (wr) target <= wr_width;
      if (wrap) cur <= slew_step(cur, target, STEP_W);
    end
  assign pwm = enable_q && (count < cur);
  assign at_target = cur == target;
endmodule

// File: rtl/servo_frame_scheduler.sv
// servo_frame_scheduler: frame counter, command FSM and NUM_CH slew-limited servo PWM channels
//   clk, rst                     clock, async active-high reset
//   enable                       PWM enable, latched at the frame boundary
//   cmd_valid/cmd_ready          command handshake; cmd_ch, cmd_pos carry channel and position
//   pwm                          servo pulse outputs
//   frame_start                  counter is 0
//   busy                         some channel is still ramping
//   cmd_err                      one-cycle pulse for an out-of-range channel command
module servo_frame_scheduler import servo_pkg::*; #(
  parameter int FRAME_TICKS = 1_000_000,
  parameter int NUM_CH = 5,
  parameter int MIN_PULSE = 50_000,
  parameter int POS_SCALE = 196,
  parameter int STEP = 500,
  parameter int RESET_POS = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_ch,
  input  logic [7:0]        cmd_pos,
  output logic [NUM_CH-1:0] pwm,
  output logic              frame_start,
  output logic              busy,
  output logic              cmd_err
);
  localparam width_t LAST = width_t'(FRAME_TICKS - 1);
  localparam width_t INIT = pos_to_width(8'(RESET_POS), width_t'(MIN_PULSE), width_t'(POS_SCALE));
  width_t count, wr_width;
  state_t state, state_nx;
  ch_idx_t ch_q;
  logic [7:0] pos_q;
  logic enable_q, wrap, write;
  logic [NUM_CH-1:0] at_target;
  assign wrap = count == LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count <= '0;
      state <= IDLE;
      enable_q <= 1'b0;
      ch_q <= '0;
      pos_q <= '0;
    end else begin
      count <= wrap ? '0 : count + width_t'(1);
      state <= state_nx;
      if (wrap) enable_q <= enable;
      if (cmd_valid && cmd_ready) begin
        ch_q <= cmd_ch;
        pos_q <= cmd_pos;
      end
    end
  always_comb begin
    state_nx = state;
    cmd_ready = state == IDLE;
    write = state == WRITE;
    cmd_err = write && (int'(ch_q) >= NUM_CH);
    state_nx = write ? IDLE : (cmd_valid ? WRITE : IDLE);
  end
  assign wr_width = pos_to_width(pos_q, width_t'(MIN_PULSE), width_t'(POS_SCALE));
  assign frame_start = count == '0;
  assign busy = ~&at_target;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    servo_slew_channel #(.INIT(INIT), .STEP_W(width_t'(STEP))) u_ch (
      .clk(clk),
      .rst(rst),
      .wr(write && ch_q == ch_idx_t'(i)),
      .wr_width(wr_width),
      .wrap(wrap),
      .count(count),
      .enable_q(enable_q),
      .pwm(pwm[i]),
      .at_target(at_target[i])
    );
  end
endmodule

// File: tb/tb_servo_frame_scheduler.sv
// tb_servo_frame_scheduler: scoreboard bench measuring per-frame pulse widths against a frame-level model
module tb_servo_frame_scheduler;
  localparam int FT = 1000, NCH = 5, MINP = 100, SC = 1, ST = 10, RP = 128;
  localparam int INIT = MINP + RP * SC;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b1, cmd_valid = 1'b0;
  logic [2:0] cmd_ch = '0;
  logic [7:0] cmd_pos = '0;
  logic cmd_ready, frame_start, busy, cmd_err;
  logic [NCH-1:0] pwm;
  int n_chk = 0, n_pass = 0;
  int m_tgt[NCH], m_cur[NCH], hi[NCH];
  bit m_en, armed;
  int exp_q[$];
  always #5 clk = ~clk;
  servo_frame_scheduler #(
    .FRAME_TICKS(FT), .NUM_CH(NCH), .MIN_PULSE(MINP), .POS_SCALE(SC), .STEP(ST), .RESET_POS(RP)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_pos(cmd_pos), .pwm(pwm), .frame_start(frame_start),
    .busy(busy), .cmd_err(cmd_err)
  );
  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  function automatic int model_busy();
    int b = 0;
    for (int i = 0; i < NCH; i++) if (m_cur[i] != m_tgt[i]) b = 1;
    return b;
  endfunction
  always @(negedge clk) begin
    if (rst) begin
      armed = 0;
      m_en = 0;
      exp_q.delete();
      for (int i = 0; i < NCH; i++) begin
        m_tgt[i] = INIT;
        m_cur[i] = INIT;
        hi[i] = 0;
      end
    end else begin
      if (frame_start) begin
        if (armed) begin
          for (int i = 0; i < NCH; i++) chk($sformatf("width_ch%0d", i), hi[i], exp_q.pop_front());
          for (int i = 0; i < NCH; i++)
            if (m_cur[i] < m_tgt[i]) m_cur[i] = (m_tgt[i] - m_cur[i] > ST) ? m_cur[i] + ST : m_tgt[i];
            else if (m_cur[i] > m_tgt[i]) m_cur[i] = (m_cur[i] - m_tgt[i] > ST) ? m_cur[i] - ST : m_tgt[i];
          m_en = enable;
        end
        armed = 1;
        for (int i = 0; i < NCH; i++) begin
          exp_q.push_back(m_en ? m_cur[i] : 0);
          hi[i] = 0;
        end
        chk("busy_at_frame", busy, model_busy());
      end
      for (int i = 0; i < NCH; i++) hi[i] += int'(pwm[i]);
    end
  end
  task automatic wait_pos(int pos);
    int k = 0;
    @(negedge clk);
    while (!frame_start && k < 2 * FT) begin
      @(negedge clk);
      k++;
    end
    if (!frame_start) chk("frame_start_timeout", 0, 1);
    repeat (pos) @(negedge clk);
  endtask
  task automatic frames(int n);
    repeat (n) wait_pos(0);
  endtask
  task automatic send(int ch, int pos);
    chk("ready_idle", cmd_ready, 1);
    cmd_valid = 1;
    cmd_ch = 3'(ch);
    cmd_pos = 8'(pos);
    if (ch < NCH) m_tgt[ch] = MINP + pos * SC;
    @(negedge clk);
    cmd_valid = 0;
    chk("ready_write", cmd_ready, 0);
    chk("err_write", cmd_err, int'(ch >= NCH));
    @(negedge clk);
    chk("ready_back", cmd_ready, 1);
    chk("err_after", cmd_err, 0);
  endtask
  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_pwm", pwm, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_frame_start", frame_start, 1);
    chk("rst_busy", busy, 0);
    chk("rst_err", cmd_err, 0);
    @(posedge clk);
    #1 rst = 0;
    frames(3);
    wait_pos(300);
    send(7, 0);
    wait_pos(300);
    cmd_valid = 1;
    cmd_ch = 3'd0;
    cmd_pos = 8'd0;
    m_tgt[0] = MINP;
    chk("b2b_ready0", cmd_ready, 1);
    @(negedge clk);
    chk("b2b_ready1", cmd_ready, 0);
    cmd_pos = 8'd50;
    @(negedge clk);
    chk("b2b_ready2", cmd_ready, 1);
    m_tgt[0] = MINP + 50 * SC;
    @(negedge clk);
    chk("b2b_ready3", cmd_ready, 0);
    @(negedge clk);
    chk("b2b_ready4", cmd_ready, 1);
    cmd_valid = 0;
    frames(9);
    wait_pos(400);
    enable = 0;
    wait_pos(50);
    chk("pwm_disabled", pwm, 0);
    repeat (50) @(negedge clk);
    enable = 1;
    frames(2);
    wait_pos(300);
    send(2, 255);
    frames(15);
    wait_pos(300);
    send(2, 0);
    frames(3);
    wait_pos(100);
    chk("pwm_before_rst", pwm, 5'h1f);
    #2 rst = 1;
    #1 chk("pwm_async_rst", pwm, 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 0;
    frames(3);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/servo_frame_scheduler.md
# servo_frame_scheduler

Sequences the finger-servo PWM datapath of the hand controller. It accepts per-channel position commands over a valid/ready handshake, converts each to a pulse width, and slew-limits every channel toward its target once per PWM frame. From one shared frame counter it drives `NUM_CH` glitch-free servo PWM outputs, so width changes never occur mid-pulse.

## Interface
- `FRAME_TICKS`, default 1_000_000: clock ticks per PWM frame (20 ms at 50 MHz).
- `NUM_CH`, default 5: number of servo channels.
- `MIN_PULSE`, default 50_000: pulse width in ticks for position 0.
- `POS_SCALE`, default 196: ticks per position LSB.
- `STEP`, default 500: maximum width change per channel per frame, in ticks. 0 means jump directly to the target.
- `RESET_POS`, default 128: position loaded into every channel's target and current width at reset.
- `clk` in, 1: system clock.
- `rst` in, 1: reset. Asynchronous, active-high.
- `enable` in, 1: PWM output enable. Sampled only at the frame boundary.
- `cmd_valid` in, 1: position command valid.
- `cmd_ready` out, 1: block can accept a command.
- `cmd_ch` in, 3: target channel index.
- `cmd_pos` in, 8: position, 0–255.
- `pwm` out, `NUM_CH`: servo pulse outputs.
- `frame_start` out, 1: high during the cycle in which the frame counter equals 0.
- `busy` out, 1: high while any channel's current width differs from its target.
- `cmd_err` out, 1: one-cycle pulse when an accepted command has `cmd_ch >= NUM_CH`.

## Operation
- **Frame counter**
  - 28-bit counter runs 0 to `FRAME_TICKS-1`, then wraps to 0.
- **Command FSM**
  - Two states: IDLE and WRITE.
  - `cmd_ready` = (state == IDLE).
  - In IDLE, `cmd_valid && cmd_ready` captures `cmd_ch`/`cmd_pos` and moves to WRITE.
  - WRITE computes `MIN_PULSE + cmd_pos*POS_SCALE` (28-bit, unsigned), stores it in `target[cmd_ch]`, and returns to IDLE.
  - If `cmd_ch` is out of range, WRITE pulses `cmd_err` and no target changes.
- **Frame update** (on the edge where the counter wraps `FRAME_TICKS-1` → 0):
  - For each channel: if `cur < target`, `cur = min(cur+STEP, target)`; if `cur > target`, `cur = max(cur-STEP, target)`; otherwise hold.
  - `enable_q` ← `enable` on the same edge.
- **Output**
  - `pwm[i] = enable_q && (counter < cur[i])`: exactly `cur[i]` ticks high per frame.
  - Widths `>= FRAME_TICKS` give a constant high output.
- **Reset**
  - Counter 0, FSM IDLE, `enable_q` 0.
  - `target[i]` = `cur[i]` = `MIN_PULSE + RESET_POS*POS_SCALE`.
  - Outputs: `pwm` 0, `cmd_err` 0, `busy` 0, `cmd_ready` 1, `frame_start` 1.
- **Reset asserted mid-operation**: `pwm` drops to 0 immediately (asynchronous path) and all ramps are abandoned.

## Timing
- **Command latency**: handshake cycle N, target written at the end of cycle N+1, `cmd_ready` high again in N+2. Maximum throughput is one command per 2 cycles.
- **Effect on pulse width**: a target written no later than the wrap edge takes part in that edge's update only if it was stored before it. If WRITE completes on the wrap edge itself, the update uses the old target and the new value applies one frame later.
- **Same channel twice in one frame**: the last write wins.
- **First frame after reset** has `enable_q` = 0, so PWM output begins in the second frame at the earliest.
- **`busy`** is combinational from the `cur`/`target` compare. It can rise one cycle after WRITE and falls on the wrap edge that makes all channels equal.
- **Disabling**: when `enable` falls mid-frame, the current frame completes unchanged and `pwm` goes low from the next frame.

## Structure
- **Package `servo_pkg`**:
  - `width_t` (28-bit pulse-width type) and `ch_idx_t` (3-bit channel-index type).
  - FSM state enum (IDLE, WRITE).
  - `slew_step(cur, tgt, step)` function.
  - Position-to-width conversion function.
- **Sub-module `servo_slew_channel`**, instantiated `NUM_CH` times:
  - Holds `target` and `cur`.
  - Takes a write strobe, a wrap strobe, the counter, and `enable_q`.
  - Produces `pwm` and `at_target`.
- **Top level** holds the frame counter, the command FSM, `enable_q`, and the `busy` OR-reduction.

## Test plan
Bench parameters: `FRAME_TICKS`=1000, `MIN_PULSE`=100, `POS_SCALE`=1, `STEP`=10, `NUM_CH`=5, `RESET_POS`=128.

1. **Reset, no commands.** Release reset with `enable`=1 and issue no commands → frame 1: all `pwm` low. Every frame from frame 2: each `pwm` high for exactly 228 cycles. `busy`=0 and `cmd_ready`=1 throughout.
2. **Ramp up.** Command ch2, pos 255 (target 355) → ch2 widths 238, 248, …, 348, then 355 on the 13th update. `busy` falls on that wrap edge. Other channels stay at 228.
3. **Out-of-range channel.** Command ch7, pos 0 → `cmd_err` high for exactly one cycle. No width changes. `cmd_ready` is low for one cycle.
4. **Back-to-back commands.** ch0 pos 0, then ch0 pos 50 in the same frame → ch0 ramps toward 150 (218, 208, …, 150). The pos 0 target is never used. `cmd_valid` held high shows `cmd_ready` toggling every other cycle.
5. **Disable mid-frame.** Drop `enable` at counter 400, during a frame in which every `pwm` is already enabled → that frame's pulses are unchanged (228 high). The following frame is all-low. Re-assert `enable` → pulses resume one frame boundary later.
6. **Reset mid-ramp.** Assert `rst` mid-ramp of test 2 at counter 100 → `pwm` low in the same cycle (before the next clock edge). After release, ch2 is back to 228 and `busy`=0.
